umod_down_counter: RTL and testbench
====================================

Name: umod_down_counter

Overview:
- Programmable modulo-M down counter; the counting-down counterpart of the team's modulo up counter.
- Serves timeout, reload and period generation in the same designs.
- Counts from M-1 down to 0 and wraps back to M-1.
- Supports synchronous load of start value and modulus, count enable, registered terminal-count pulse and zero flag.

Parameters:
- N, 6, counter width in bits.
- MOD, 60, default modulus used after reset and when a loaded modulus is invalid. Must satisfy 2 <= MOD <= 2^N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  count enable; one decrement per clk while high.
- load  input  1  synchronous load strobe; takes priority over en.
- load_val  input  N  start value captured on load.
- mod_val  input  N  new modulus captured on load. The value 0 encodes 2^N.
- count  output  N  current count value (registered).
- tc  output  1  terminal-count pulse (registered), one cycle per wrap.
- zero  output  1  combinational flag, high when count == 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - count = MOD-1, tc = 0, internal modulus register mod_q = MOD, FSM = RUN.
  - zero = 0, because count is nonzero.
  - Release is synchronous to the next clk edge; the first decrement occurs on the first rising edge with rst=1 and en=1.
- Modulus decode (on load):
  - mod_val = 0 means 2^N.
  - mod_val = 1 is invalid: mod_q = MOD.
  - Any other mod_val: mod_q = mod_val.
- Load (load=1, any en):
  - mod_q is updated as above.
  - count = load_val if load_val < new mod_q; otherwise count = new mod_q - 1 (saturate).
  - tc = 0 that cycle.
  - FSM goes to RUN.
- Count (load=0, en=1, FSM=RUN):
  - If count > 0: count = count - 1, tc = 0.
  - If count == 0: count = mod_q - 1, tc = 1 for exactly one cycle (coincident with count showing mod_q - 1).
- Hold (load=0, en=0): count holds, tc = 0.
- Latency: count, tc and state change one clk edge after the sampled inputs. zero follows count combinationally.
- FSM states:
  - RUN: normal operation.
  - DONE: used only with the optional feature. With the feature compiled out, DONE is unreachable.
- Width rules:
  - All compare and subtract operations are N bits wide.
  - mod_q is N+1 bits wide so that it can hold 2^N.
  - The mod_q - 1 reload never exceeds 2^N - 1.
- Boundaries:
  - load and count==0 with en=1 in the same cycle: load wins, no tc.
  - Mid-count reset: immediate return to reset values and mod_q = MOD; any previously loaded modulus is discarded.
  - tc never asserts on two consecutive cycles unless mod_q = 1, which is impossible because mod_q >= 2.

Optional Feature:
- Macro: UMOD_DOWN_ONESHOT_EN.
- Defined (one-shot operation):
  - In RUN, en=1 with count == 0 makes count stay 0, tc = 1 for one cycle, and FSM moves to DONE.
  - In DONE, en is ignored: count stays 0 and tc = 0.
  - Only load, or reset, returns the FSM to RUN.
  - Reset state is unchanged: count = MOD-1, RUN.
- Not defined: free-running wrap as described in Behaviour; no DONE state logic is synthesized.

Test Plan:
1. Reset then free run: rst=0 for 20 ns, then rst=1, en=1 -> count 59, 58, ..., 0, then 59. tc=1 only in the cycle count=59 after the wrap. zero=1 only while count=0.
2. Load with valid modulus: load=1, load_val=3, mod_val=5, then en=1 -> count 3, 2, 1, 0, 4 (tc=1), 3, 2, ...
3. Saturating and invalid load: load_val=9, mod_val=5 -> count=4. Then load_val=2, mod_val=1 -> mod_q=60, count=2. Then mod_val=0 (N=6) -> wrap from 0 to 63.
4. Enable gaps and priority: toggle en off for 3 cycles at count=10 -> count holds at 10, tc=0. Assert load together with en at count=0 -> count=load_val, tc stays 0.
5. Async reset mid-count: after a load to mod 5 and count=2, drive rst=0 between clock edges -> count=59 immediately with no clock edge, tc=0. After release, the counter wraps at modulus 60.
6. One-shot (UMOD_DOWN_ONESHOT_EN defined): load_val=2 with en=1 -> count 2, 1, 0. tc pulses once, then count stays 0 for 10+ cycles with tc=0. A subsequent load of 4 restarts the count at 4, 3, ...

Source files
------------

// File: rtl/umod_down_counter.sv
//==============================================================================
// Module   : umod_down_counter
// Purpose  : Programmable modulo-M down counter. Counts from mod-1 down to 0
//            and wraps back to mod-1, emitting a one-cycle registered tc pulse
//            on each wrap. Start value and modulus are loaded synchronously.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous reset, active low
//            en       - count enable, one decrement per clock while high
//            load     - synchronous load strobe, priority over en
//            load_val - start value captured on load (saturated to mod-1)
//            mod_val  - modulus captured on load (0 = 2^N, 1 = use MOD)
//            count    - registered count value
//            tc       - registered terminal-count pulse
//            zero     - combinational flag, count == 0
// Options  : UMOD_DOWN_ONESHOT_EN - when defined, the counter stops at 0 after
//            its terminal count (DONE state) until the next load or reset.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module umod_down_counter #(
    parameter int N   = 6,
    parameter int MOD = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] mod_val,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         zero
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Modulus register is one bit wider than the count so it can hold 2^N.
    localparam logic [N:0]   c_MOD       = (N+1)'(MOD);
    localparam logic [N-1:0] c_COUNT_RST = N'(MOD - 1);

    logic [N-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic [N:0]   mod_q, mod_d;
    state_t       state_q, state_d;

    logic [N:0]   w_new_mod;
    logic [N-1:0] w_new_mod_m1;
    logic [N-1:0] w_mod_m1;

    // Decode the incoming modulus: 0 stands for 2^N, 1 is meaningless for a
    // counter and falls back to the default modulus.
    always_comb begin
        w_new_mod = {1'b0, mod_val};
        if (mod_val == '0) begin
            w_new_mod = {1'b1, {N{1'b0}}};
        end else if (mod_val == N'(1)) begin
            w_new_mod = c_MOD;
        end
    end

    // Modulus is always >= 2, so modulus-1 always fits in N bits.
    assign w_new_mod_m1 = N'(w_new_mod - 1'b1);
    assign w_mod_m1     = N'(mod_q - 1'b1);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        mod_d   = mod_q;
        state_d = state_q;

        if (load) begin
            mod_d   = w_new_mod;
            // load_val < new modulus is the same test as load_val <= modulus-1,
            // which keeps the comparison N bits wide.
            count_d = (load_val <= w_new_mod_m1) ? load_val : w_new_mod_m1;
            state_d = ST_RUN;
        end else if (en) begin
`ifdef UMOD_DOWN_ONESHOT_EN
            if (state_q == ST_RUN) begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    // Stay parked at zero; only load or reset restarts.
                    tc_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end
`else
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                count_d = w_mod_m1;
                tc_d    = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= c_COUNT_RST;
            tc_q    <= 1'b0;
            mod_q   <= c_MOD;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            mod_q   <= mod_d;
            state_q <= state_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign zero  = (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_umod_down_counter.sv
//==============================================================================
// Module   : tb_umod_down_counter
// Purpose  : Self-checking bench for umod_down_counter (N=6, MOD=60).
//            Directed stimulus pushes hand-computed expectations into a queue;
//            an independent monitor pops one entry per clock and compares.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_umod_down_counter;

`ifdef UMOD_DOWN_ONESHOT_EN
    localparam bit c_ONESHOT = 1'b1;
`else
    localparam bit c_ONESHOT = 1'b0;
`endif

    typedef struct {
        int         id;
        logic [5:0] cnt;
        logic       tc;
        logic       zero;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [5:0] load_val;
    logic [5:0] mod_val;
    logic [5:0] count;
    logic       tc;
    logic       zero;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_id = 0;

    umod_down_counter #(
        .N   (6),
        .MOD (60)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mod_val  (mod_val),
        .count    (count),
        .tc       (tc),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input int id, input logic [5:0] ec, input logic et, input logic ez);
        checks++;
        if (count !== ec || tc !== et || zero !== ez) begin
            errors++;
            $display("FAIL step%0d: count=%0d tc=%b zero=%b, expected count=%0d tc=%b zero=%b",
                     id, count, tc, zero, ec, et, ez);
        end
    endtask

    // One clock of stimulus; the expected post-edge state goes to the scoreboard.
    task automatic step(input logic e, input logic l, input logic [5:0] lv,
                        input logic [5:0] mv, input logic [5:0] ec, input logic et);
        exp_t x;
        @(negedge clk);
        en       = e;
        load     = l;
        load_val = lv;
        mod_val  = mv;
        step_id++;
        x.id   = step_id;
        x.cnt  = ec;
        x.tc   = et;
        x.zero = (ec == 6'd0);
        q.push_back(x);
    endtask

    // Monitor: the DUT presents a new state every clock.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                compare(x.id, x.cnt, x.tc, x.zero);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; mod_val = '0;

        // Reset state, checked while reset is held
        #12;
        compare(0, 6'd59, 1'b0, 1'b0);
        #8;
        rst = 1'b1;   // t=20, a falling clock edge

        // 1. Free run from 59 through 0 and wrap
        for (int i = 58; i >= 0; i--) step(1, 0, 0, 0, 6'(i), 0);
        step(1, 0, 0, 0, c_ONESHOT ? 6'd0 : 6'd59, 1);
        step(1, 0, 0, 0, c_ONESHOT ? 6'd0 : 6'd58, 0);

        // 2. Load valid modulus 5, start 3
        step(0, 1, 6'd3, 6'd5, 6'd3, 0);
        step(1, 0, 0, 0, 6'd2, 0);
        step(1, 0, 0, 0, 6'd1, 0);
        step(1, 0, 0, 0, 6'd0, 0);
        step(1, 0, 0, 0, c_ONESHOT ? 6'd0 : 6'd4, 1);
        step(1, 0, 0, 0, c_ONESHOT ? 6'd0 : 6'd3, 0);

        // 3. Saturating load, invalid modulus, modulus 0 meaning 64
        step(0, 1, 6'd9, 6'd5, 6'd4, 0);
        step(0, 1, 6'd2, 6'd1, 6'd2, 0);
        step(1, 0, 0, 0, 6'd1, 0);
        step(1, 0, 0, 0, 6'd0, 0);
        step(1, 0, 0, 0, c_ONESHOT ? 6'd0 : 6'd59, 1);
        step(0, 1, 6'd63, 6'd0, 6'd63, 0);
        step(0, 1, 6'd1, 6'd0, 6'd1, 0);
        step(1, 0, 0, 0, 6'd0, 0);
        step(1, 0, 0, 0, c_ONESHOT ? 6'd0 : 6'd63, 1);
        step(1, 0, 0, 0, c_ONESHOT ? 6'd0 : 6'd62, 0);

        // 4. Enable gaps, then load colliding with count==0 and en
        step(0, 1, 6'd12, 6'd20, 6'd12, 0);
        step(1, 0, 0, 0, 6'd11, 0);
        step(1, 0, 0, 0, 6'd10, 0);
        step(0, 0, 0, 0, 6'd10, 0);
        step(0, 0, 0, 0, 6'd10, 0);
        step(0, 0, 0, 0, 6'd10, 0);
        step(1, 0, 0, 0, 6'd9, 0);
        step(0, 1, 6'd0, 6'd20, 6'd0, 0);
        step(1, 1, 6'd7, 6'd20, 6'd7, 0);
        step(1, 0, 0, 0, 6'd6, 0);

        // 5. Asynchronous reset between clock edges
        step(0, 1, 6'd2, 6'd5, 6'd2, 0);
        @(negedge clk);
        en = 1'b0; load = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        compare(-1, 6'd59, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 58; i >= 0; i--) step(1, 0, 0, 0, 6'(i), 0);
        step(1, 0, 0, 0, c_ONESHOT ? 6'd0 : 6'd59, 1);

`ifdef UMOD_DOWN_ONESHOT_EN
        // 6. One-shot: stops at zero until reloaded
        step(1, 1, 6'd2, 6'd5, 6'd2, 0);
        step(1, 0, 0, 0, 6'd1, 0);
        step(1, 0, 0, 0, 6'd0, 0);
        step(1, 0, 0, 0, 6'd0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 6'd0, 0);
        step(1, 1, 6'd4, 6'd5, 6'd4, 0);
        step(1, 0, 0, 0, 6'd3, 0);
`endif

        @(negedge clk);
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
